fwd_sel_unit: RTL and testbench
===============================

// Module: fwd_sel_unit
// PURPOSE
//  Producer side of the 3-way operand select. Tracks the destination registers of
//  in-flight instructions and drives the 2-bit cntl of both EX operand MUXes.
//  Detects load-use hazards and emits a stall plus bubble. Sits beside ID/EX and is
//  clocked with the pipeline registers.
// PARAMETERS
//  REG_ADDR_W  5   register-specifier width
//  CNT_W       16  width of saturating stall counter
// PORTS
//  clk             in   1           pipeline clock, rising edge
//  rst             in   1           synchronous, active-high reset
//  id_valid        in   1           ID holds a real instruction
//  id_rs           in   REG_ADDR_W  source A specifier
//  id_rt           in   REG_ADDR_W  source B specifier
//  id_uses_rs      in   1           instruction reads rs
//  id_uses_rt      in   1           instruction reads rt
//  id_dest         in   REG_ADDR_W  destination specifier
//  id_reg_write    in   1           instruction writes id_dest
//  id_mem_read     in   1           instruction is a load
//  flush           in   1           squash the instruction in ID (branch taken)
//  ex_sel_a        out  2           cntl for operand-A MUX (registered)
//  ex_sel_b        out  2           cntl for operand-B MUX (registered)
//  stall           out  1           hold PC and IF/ID; insert bubble (combinational)
//  stall_cnt       out  CNT_W       cycles stalled since reset, saturating
// BEHAVIOUR
//  - Select codes: 2'b00 register-file value, 2'b01 EX/MEM ALU result,
//    2'b10 MEM/WB writeback value. 2'b11 is never driven.
//  - Shadow entries ex_q, mem_q = {valid, dest, reg_write, mem_read}. Each clock:
//    mem_q <= ex_q; ex_q <= ID entry, or a bubble (valid=0) on stall/flush/!id_valid.
//  - Match X(r) = uses_r & X.valid & X.reg_write & (X.dest == r) & (r != 0).
//  - Select for rs, registered into ex_sel_a on the same edge ID enters EX:
//    Match ex_q(rs) -> 01; else Match mem_q(rs) -> 10; else 00.
//    EX/MEM has priority over MEM/WB. ex_sel_b is computed the same way from rt.
//  - Register-file write-before-read covers WB-stage producers. No third entry.
//  - stall = id_valid & !flush & ex_q.mem_read & (Match ex_q(rs) | Match ex_q(rt)).
//    During stall, ex_sel_a/b <= 00 for the bubble. The next cycle the load is in
//    mem_q, so the held instruction gets 10.
//  - Latency: selects are valid 1 cycle after ID presentation; stall is 0-cycle.
//  - A stall lasts exactly one cycle per load-use pair. A second stall in a row is
//    impossible by construction; flag one with an assertion.
//  - flush has priority over stall: stall=0, bubble inserted, selects 00.
//  - !id_valid: bubble inserted, selects 00, stall=0.
//  - stall_cnt increments on each stall cycle and saturates at all-ones (no wrap).
//  - Reset: ex_q, mem_q invalid; ex_sel_a = ex_sel_b = 00; stall_cnt = 0; stall = 0.
//    Reset asserted mid-stall clears everything at the next edge.
// STRUCTURE
//  - Shared package: localparams SEL_RF=2'b00, SEL_EXMEM=2'b01, SEL_MEMWB=2'b10.
//    The EX operand MUX instances use the same constants.
//  - Sub-module fwd_match: combinational compare of one specifier against ex_q and
//    mem_q, returning a select code and a load-hit flag. Instantiate it twice (rs, rt).
// TESTING
//  1. add r3 then add r4,r3,r5 back-to-back -> ex_sel_a=01 next cycle, stall=0.
//  2. add r3, nop, sub r6,r1,r3 -> ex_sel_b=10; same dest in both slots -> 01 wins.
//  3. lw r2 then add r7,r2,r2 -> stall=1 for one cycle, bubble selects 00;
//     next cycle ex_sel_a=ex_sel_b=10; stall_cnt increments by 1.
//  4. Producer writes r0, consumer reads r0 -> selects 00 and no stall, even after lw r0.
//  5. Load-use with flush=1 in the same cycle -> stall=0, bubble, selects 00.
//     Consumer with id_uses_rt=0 and an rt match -> ex_sel_b=00.
//  6. Force 2^CNT_W+3 stalls (CNT_W=4 build) -> stall_cnt holds 4'hF.
//     Assert rst mid-stall -> next cycle all outputs 0.

Source files
------------

// File: rtl/fwd_sel_unit_pkg.sv
// Shared operand-select encodings for the forwarding unit and the EX operand MUXes.
package fwd_sel_unit_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_RF    = 2'b00;
  localparam sel_t SEL_EXMEM = 2'b01;
  localparam sel_t SEL_MEMWB = 2'b10;

  // The younger producer (EX/MEM) always wins over the older one (MEM/WB).
  function automatic sel_t sel_pick(input logic ex_hit, input logic mem_hit);
    if (ex_hit)       return SEL_EXMEM;
    else if (mem_hit) return SEL_MEMWB;
    else              return SEL_RF;
  endfunction

endpackage

// File: rtl/fwd_sel_unit_match.sv
// Compares one source specifier against the EX and MEM shadow entries.
module fwd_match
  import fwd_sel_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  uses_i,
  input  logic [REG_ADDR_W-1:0] spec_i,
  input  logic                  ex_valid_i,
  input  logic                  ex_reg_write_i,
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_dest_i,
  input  logic                  mem_valid_i,
  input  logic                  mem_reg_write_i,
  input  logic [REG_ADDR_W-1:0] mem_dest_i,
  output sel_t                  sel_o,
  output logic                  load_hit_o
);

  logic live, ex_hit, mem_hit;

  // r0 is hardwired zero, so it is never a forwarding source.
  assign live       = uses_i & (|spec_i);
  assign ex_hit     = live & ex_valid_i  & ex_reg_write_i  & (ex_dest_i  == spec_i);
  assign mem_hit    = live & mem_valid_i & mem_reg_write_i & (mem_dest_i == spec_i);
  assign sel_o      = sel_pick(ex_hit, mem_hit);
  assign load_hit_o = ex_hit & ex_mem_read_i;

endmodule

// File: rtl/fwd_sel_unit.sv
// Forwarding select and load-use stall generator; tracks dests of the EX and MEM stages.
module fwd_sel_unit
  import fwd_sel_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_uses_rs_i,
  input  logic                  id_uses_rt_i,
  input  logic [REG_ADDR_W-1:0] id_dest_i,
  input  logic                  id_reg_write_i,
  input  logic                  id_mem_read_i,
  input  logic                  flush_i,
  output sel_t                  ex_sel_a_o,
  output sel_t                  ex_sel_b_o,
  output logic                  stall_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
    logic                  reg_write;
    logic                  mem_read;
  } ex_ent_t;

  // Load-ness is irrelevant once the producer reaches MEM: its data is on the WB path.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
    logic                  reg_write;
  } mem_ent_t;

  ex_ent_t          ex_q, ex_d;
  mem_ent_t         mem_q;
  sel_t             sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  sel_t             match_a, match_b;
  logic             hit_a, hit_b, bubble, stall_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_a (
    .uses_i(id_uses_rs_i), .spec_i(id_rs_i),
    .ex_valid_i(ex_q.valid), .ex_reg_write_i(ex_q.reg_write),
    .ex_mem_read_i(ex_q.mem_read), .ex_dest_i(ex_q.dest),
    .mem_valid_i(mem_q.valid), .mem_reg_write_i(mem_q.reg_write),
    .mem_dest_i(mem_q.dest), .sel_o(match_a), .load_hit_o(hit_a)
  );

  fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_b (
    .uses_i(id_uses_rt_i), .spec_i(id_rt_i),
    .ex_valid_i(ex_q.valid), .ex_reg_write_i(ex_q.reg_write),
    .ex_mem_read_i(ex_q.mem_read), .ex_dest_i(ex_q.dest),
    .mem_valid_i(mem_q.valid), .mem_reg_write_i(mem_q.reg_write),
    .mem_dest_i(mem_q.dest), .sel_o(match_b), .load_hit_o(hit_b)
  );

  always_comb begin
    stall_o     = id_valid_i & ~flush_i & (hit_a | hit_b);
    bubble      = stall_o | flush_i | ~id_valid_i;
    ex_d        = '0;
    sel_a_d     = SEL_RF;
    sel_b_d     = SEL_RF;
    stall_cnt_d = stall_cnt_q;
    if (!bubble) begin
      ex_d    = '{valid: 1'b1, dest: id_dest_i, reg_write: id_reg_write_i,
                  mem_read: id_mem_read_i};
      sel_a_d = match_a;
      sel_b_d = match_b;
    end
    if (stall_o && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q        <= '0;
      mem_q       <= '0;
      sel_a_q     <= SEL_RF;
      sel_b_q     <= SEL_RF;
      stall_cnt_q <= '0;
      stall_q     <= 1'b0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= '{valid: ex_q.valid, dest: ex_q.dest, reg_write: ex_q.reg_write};
      sel_a_q     <= sel_a_d;
      sel_b_q     <= sel_b_d;
      stall_cnt_q <= stall_cnt_d;
      stall_q     <= stall_o;
    end
  end

  // The bubble behind a stall can never be a load, so stalls cannot chain.
  a_no_back_to_back_stall: assert property (@(posedge clk_i) disable iff (rst_i)
    !(stall_q && stall_o));

  assign ex_sel_a_o  = sel_a_q;
  assign ex_sel_b_o  = sel_b_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fwd_sel_unit.sv
// Directed bench for fwd_sel_unit (CNT_W=4) with a scoreboard of registered results.
module tb_fwd_sel_unit;
  localparam int W = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, flush;
  logic [W-1:0]  id_rs, id_rt, id_dest;
  logic [1:0]    ex_sel_a, ex_sel_b;
  logic          stall;
  logic [CW-1:0] stall_cnt;

  typedef struct {
    logic [1:0]    a;
    logic [1:0]    b;
    logic [CW-1:0] cnt;
    int            step;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            step_no = 0;
  logic [CW-1:0] exp_cnt = '0;

  fwd_sel_unit #(.REG_ADDR_W(W), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_uses_rs_i(id_uses_rs), .id_uses_rt_i(id_uses_rt), .id_dest_i(id_dest),
    .id_reg_write_i(id_reg_write), .id_mem_read_i(id_mem_read), .flush_i(flush),
    .ex_sel_a_o(ex_sel_a), .ex_sel_b_o(ex_sel_b), .stall_o(stall), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s step %0d: observed %0h expected %0h", tag, step_no, obs, exp);
    end
  endtask

  // Drive one ID slot at negedge, check the combinational stall, queue the registered results.
  task automatic step(input logic v, input logic [W-1:0] rs, input logic [W-1:0] rt,
                      input logic urs, input logic urt, input logic [W-1:0] dst,
                      input logic rw, input logic mr, input logic fl,
                      input logic est, input logic [1:0] ea, input logic [1:0] eb);
    exp_t e, got;
    @(negedge clk);
    step_no++;
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_dest = dst; id_reg_write = rw; id_mem_read = mr; flush = fl;
    #1;
    chk("stall", {7'd0, stall}, {7'd0, est});
    if (est && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
    e.a = ea; e.b = eb; e.cnt = exp_cnt; e.step = step_no;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $error("FAIL scoreboard_empty step %0d: observed 0 entries expected 1", step_no);
    end else begin
      got = sb.pop_front();
      chk("ex_sel_a", {6'd0, ex_sel_a}, {6'd0, got.a});
      chk("ex_sel_b", {6'd0, ex_sel_b}, {6'd0, got.b});
      chk("stall_cnt", {4'd0, stall_cnt}, {4'd0, got.cnt});
    end
  endtask

  task automatic instr(input logic [W-1:0] rs, input logic [W-1:0] rt, input logic urs,
                       input logic urt, input logic [W-1:0] dst, input logic rw,
                       input logic mr, input logic est, input logic [1:0] ea,
                       input logic [1:0] eb);
    step(1'b1, rs, rt, urs, urt, dst, rw, mr, 1'b0, est, ea, eb);
  endtask

  initial begin
    rst = 1'b1;
    id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_dest = 0; id_reg_write = 0; id_mem_read = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel_a", {6'd0, ex_sel_a}, 8'd0);
    chk("rst_sel_b", {6'd0, ex_sel_b}, 8'd0);
    chk("rst_cnt", {4'd0, stall_cnt}, 8'd0);
    chk("rst_stall", {7'd0, stall}, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: back-to-back ALU dependency -> EX/MEM forward
    instr(5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 2'b00, 2'b00);
    instr(5'd3, 5'd5, 1, 1, 5'd4, 1, 0, 0, 2'b01, 2'b00);
    // 2: one gap -> MEM/WB forward on rt; same dest in both slots -> EX/MEM wins
    instr(5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 2'b00, 2'b00);
    step(1'b0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 2'b00, 2'b00);
    instr(5'd1, 5'd3, 1, 1, 5'd6, 1, 0, 0, 2'b00, 2'b10);
    instr(5'd1, 5'd2, 1, 1, 5'd8, 1, 0, 0, 2'b00, 2'b00);
    instr(5'd1, 5'd2, 1, 1, 5'd8, 1, 0, 0, 2'b00, 2'b00);
    instr(5'd8, 5'd9, 1, 1, 5'd10, 1, 0, 0, 2'b01, 2'b00);
    // 3: load-use -> one stall with bubble, then both operands from MEM/WB
    instr(5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0, 2'b00, 2'b00);
    instr(5'd2, 5'd2, 1, 1, 5'd7, 1, 0, 1, 2'b00, 2'b00);
    instr(5'd2, 5'd2, 1, 1, 5'd7, 1, 0, 0, 2'b10, 2'b10);
    // 4: r0 is never forwarded, even from a load
    instr(5'd1, 5'd0, 1, 0, 5'd0, 1, 1, 0, 2'b00, 2'b00);
    instr(5'd0, 5'd0, 1, 1, 5'd11, 1, 0, 0, 2'b00, 2'b00);
    // 5: flush beats stall; unused rt ignores matches; !id_valid never stalls
    instr(5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0, 2'b00, 2'b00);
    step(1'b1, 5'd5, 5'd5, 1, 1, 5'd12, 1, 0, 1'b1, 0, 2'b00, 2'b00);
    instr(5'd1, 5'd5, 1, 0, 5'd12, 1, 0, 0, 2'b00, 2'b00);
    instr(5'd1, 5'd12, 1, 0, 5'd14, 1, 0, 0, 2'b00, 2'b00);
    instr(5'd1, 5'd0, 1, 0, 5'd13, 1, 1, 0, 2'b00, 2'b00);
    step(1'b0, 5'd13, 5'd13, 1, 1, 5'd15, 1, 0, 0, 0, 2'b00, 2'b00);
    // 6: saturate the stall counter (19 stalls total in a CNT_W=4 build)
    for (int i = 0; i < 18; i++) begin
      instr(5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0, 2'b00, 2'b00);
      instr(5'd2, 5'd2, 1, 1, 5'd7, 1, 0, 1, 2'b00, 2'b00);
      instr(5'd2, 5'd2, 1, 1, 5'd7, 1, 0, 0, 2'b10, 2'b10);
    end
    chk("cnt_saturated", {4'd0, stall_cnt}, 8'h0F);

    // reset asserted in the middle of a load-use stall
    instr(5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0, 2'b00, 2'b00);
    @(negedge clk);
    step_no++;
    id_valid = 1; id_rs = 5'd2; id_rt = 5'd2; id_uses_rs = 1; id_uses_rt = 1;
    id_dest = 5'd7; id_reg_write = 1; id_mem_read = 0; flush = 0;
    rst = 1'b1;
    #1;
    chk("stall_before_rst", {7'd0, stall}, 8'd1);
    @(posedge clk);
    #1;
    exp_cnt = '0;
    chk("rst_mid_sel_a", {6'd0, ex_sel_a}, 8'd0);
    chk("rst_mid_sel_b", {6'd0, ex_sel_b}, 8'd0);
    chk("rst_mid_cnt", {4'd0, stall_cnt}, {4'd0, exp_cnt});
    chk("rst_mid_stall", {7'd0, stall}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 2'b00, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
